// File: rtl/ica_result_reader.sv
// ica_result_reader
// Consumer end of the FastICA result interface. Each y_valid strobe captures
// {y4,y3,y2,y1} as one frame in a FIFO; frames are streamed out one channel
// per valid/ready transfer through a holding register.
//
// Optional build macro: ICA_SAT_OUT_EN
//   defined   - out_data saturated to signed SAT_W range, sign-extended to DATA_W
//   undefined - out_data is the raw stored sample
//
// Read FSM
//   state | meaning
//   IDLE  | holding register empty, out_valid low, pops as soon as FIFO has a frame
//   SEND  | holding register presents hold[chan]; chan 3 acceptance pops next frame
module ica_result_reader #(
    parameter int DATA_W = 26,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SAT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     y_valid,
    input  logic signed [DATA_W-1:0] y1,
    input  logic signed [DATA_W-1:0] y2,
    input  logic signed [DATA_W-1:0] y3,
    input  logic signed [DATA_W-1:0] y4,
    output logic signed [DATA_W-1:0] out_data,
    output logic [1:0]               out_chan,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [ADDR_W:0]          count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int FRAME_W = 4 * DATA_W;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [FRAME_W-1:0]   mem [DEPTH];
    logic [ADDR_W:0]      wr_ptr;
    logic [ADDR_W:0]      rd_ptr;
    logic [FRAME_W-1:0]   hold;
    logic [1:0]           chan;
    logic                 push;
    logic                 pop;
    logic                 accept;
    logic signed [DATA_W-1:0] raw;

    // Pointer-derived status; the extra MSB distinguishes full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count      = wr_ptr - rd_ptr;

    // Full is judged on start-of-cycle state, so a same-cycle pop never frees a slot.
    assign push   = y_valid && !fifo_full;
    assign accept = (state == SEND) && out_ready;
    assign pop    = !fifo_empty && ((state == IDLE) || (accept && (chan == 2'd3)));

    // Frame storage write port.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[ADDR_W-1:0]] <= {y4, y3, y2, y1};
    end

    // Write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_ptr <= '0;
        else if (push)
            wr_ptr <= wr_ptr + 1'b1;
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (y_valid && fifo_full)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    // Read FSM: holding register, channel index, read pointer and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            chan      <= 2'd0;
            hold      <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold      <= mem[rd_ptr[ADDR_W-1:0]];
                        rd_ptr    <= rd_ptr + 1'b1;
                        chan      <= 2'd0;
                        state     <= SEND;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (chan != 2'd3) begin
                            chan <= chan + 2'd1;
                        end else if (pop) begin
                            hold   <= mem[rd_ptr[ADDR_W-1:0]];
                            rd_ptr <= rd_ptr + 1'b1;
                            chan   <= 2'd0;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Select the current channel from the holding register.
    always_comb begin
        raw = hold[DATA_W-1:0];
        case (chan)
            2'd0: raw = hold[DATA_W-1:0];
            2'd1: raw = hold[2*DATA_W-1:DATA_W];
            2'd2: raw = hold[3*DATA_W-1:2*DATA_W];
            2'd3: raw = hold[4*DATA_W-1:3*DATA_W];
            default: raw = hold[DATA_W-1:0];
        endcase
    end

`ifdef ICA_SAT_OUT_EN
    // In range when all bits from the SAT_W sign bit upward agree; otherwise clamp by sign.
    always_comb begin
        if ((&raw[DATA_W-1:SAT_W-1]) || !(|raw[DATA_W-1:SAT_W-1]))
            out_data = raw;
        else
            out_data = {{(DATA_W-SAT_W+1){raw[DATA_W-1]}}, {(SAT_W-1){~raw[DATA_W-1]}}};
    end
`else
    assign out_data = raw;
`endif

    assign out_chan = chan;
    assign out_last = out_valid && (chan == 2'd3);

endmodule
